conv_pool_core: RTL and testbench

Streaming 3×3 convolution engine with 2×2 max-pooling for the convolution lab: accepts a 14×14 feature map and a 3×3 kernel on a single-beat-per-cycle input stream and returns a 6×6 pooled result as a contiguous 36-beat output burst. It is the device side of the convolution test interface: the pattern bench drives `in_valid`/`In_IFM`/`In_Weight` and checks `out_valid`/`Out_OFM`. One frame is processed at a time, and frames may be sent back-to-back after each output burst completes.

---
 rtl/conv_pool_core.sv | 153 +++++++++++++++
 tb/tb_conv_pool_core.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/conv_pool_core.sv
// rtl/conv_pool_core.sv - 14x14 frame, 3x3 valid convolution, 2x2 max-pool, 36-beat burst (CONV_SIGNED_EN selects signed arithmetic)
module conv_pool_core #(
    parameter int IN_WIDTH  = 16,
    parameter int OUT_WIDTH = 36
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [IN_WIDTH-1:0]  In_IFM,
    input  logic [IN_WIDTH-1:0]  In_Weight,
    output logic                 out_valid,
    output logic [OUT_WIDTH-1:0] Out_OFM
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_COMP = 2'd2;
    localparam logic [1:0] S_OUT  = 2'd3;

    logic [1:0]           state;
    logic [7:0]           cnt;
    logic [2:0]           pool_row;
    logic [2:0]           pool_col;
    logic [IN_WIDTH-1:0]  img [0:195];
    logic [IN_WIDTH-1:0]  wgt [0:8];
    logic [OUT_WIDTH-1:0] res [0:35];
    logic [OUT_WIDTH-1:0] run_max;
    logic [OUT_WIDTH-1:0] conv;
    logic [OUT_WIDTH-1:0] cur_max;
    logic [7:0]           base;
    logic                 load_en;

    // Operands are widened to the result width before multiplying; the low
    // OUT_WIDTH bits of the product are exact in both number systems.
    function automatic logic [OUT_WIDTH-1:0] ext(input logic [IN_WIDTH-1:0] x);
`ifdef CONV_SIGNED_EN
        return {{(OUT_WIDTH-IN_WIDTH){x[IN_WIDTH-1]}}, x};
`else
        return {{(OUT_WIDTH-IN_WIDTH){1'b0}}, x};
`endif
    endfunction

    function automatic logic greater(input logic [OUT_WIDTH-1:0] a, input logic [OUT_WIDTH-1:0] b);
`ifdef CONV_SIGNED_EN
        return $signed(a) > $signed(b);
`else
        return a > b;
`endif
    endfunction

    assign load_en = (state == S_IDLE && in_valid) || (state == S_LOAD);

    // Window origin: pool group (row, col) plus sub-window offset held in cnt[1:0]
    always_comb begin
        base = (({4'd0, pool_row, 1'b0} + {7'd0, cnt[1]}) * 8'd14)
             + {4'd0, pool_col, 1'b0} + {7'd0, cnt[0]};
    end

    // Nine parallel multipliers feeding one adder tree; running max over the pool group
    always_comb begin
        conv = '0;
        for (int m = 0; m < 3; m++) begin
            for (int n = 0; n < 3; n++) begin
                conv = conv + ext(img[base + 8'(m * 14 + n)]) * ext(wgt[4'(m * 3 + n)]);
            end
        end
        cur_max = conv;
        if (cnt[1:0] != 2'd0 && !greater(conv, run_max)) begin
            cur_max = run_max;
        end
    end

    // Frame, kernel and result storage; contents survive reset by design
    always_ff @(posedge clk) begin
        if (load_en) begin
            img[cnt] <= In_IFM;
            if (cnt < 8'd9) begin
                wgt[cnt[3:0]] <= In_Weight;
            end
        end
        if (state == S_COMP) begin
            run_max <= cur_max;
            if (cnt[1:0] == 2'd3) begin
                res[cnt[7:2]] <= cur_max;
            end
        end
    end

    // Frame sequencer: IDLE -> LOAD (196) -> COMP (144) -> OUT (36) -> IDLE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            pool_row <= '0;
            pool_col <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        state <= S_LOAD;
                        cnt   <= 8'd1;
                    end
                end
                S_LOAD: begin
                    if (cnt == 8'd195) begin
                        state    <= S_COMP;
                        cnt      <= '0;
                        pool_row <= '0;
                        pool_col <= '0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                S_COMP: begin
                    if (cnt == 8'd143) begin
                        state <= S_OUT;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                    if (cnt[1:0] == 2'd3) begin
                        if (pool_col == 3'd5) begin
                            pool_col <= '0;
                            pool_row <= pool_row + 3'd1;
                        end else begin
                            pool_col <= pool_col + 3'd1;
                        end
                    end
                end
                default: begin
                    if (cnt == 8'd35) begin
                        state <= S_IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
            endcase
        end
    end

    // Registered output stage; data is forced to zero outside the burst
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            Out_OFM   <= '0;
        end else begin
            out_valid <= (state == S_OUT);
            Out_OFM   <= (state == S_OUT) ? res[cnt[5:0]] : '0;
        end
    end

endmodule

// File: tb/tb_conv_pool_core.sv
// tb/tb_conv_pool_core.sv - scoreboard bench for conv_pool_core
module tb_conv_pool_core;

    localparam int IW = 16;
    localparam int OW = 36;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic [IW-1:0] in_ifm = '0;
    logic [IW-1:0] in_weight = '0;
    logic          out_valid;
    logic [OW-1:0] out_ofm;

    int      checks = 0;
    int      failures = 0;
    longint  cyc = 0;
    logic [OW-1:0] exp_q[$];
    longint  start_q[$];
    logic [IW-1:0] img [196];
    logic [IW-1:0] wgt [9];

    conv_pool_core #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .In_IFM(in_ifm),
        .In_Weight(in_weight), .out_valid(out_valid), .Out_OFM(out_ofm)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Golden model for arbitrary unsigned frames
    task automatic push_model();
        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < 6; c++) begin
                longint unsigned best = 0;
                for (int a = 0; a < 2; a++) begin
                    for (int b = 0; b < 2; b++) begin
                        longint unsigned s = 0;
                        for (int m = 0; m < 3; m++)
                            for (int n = 0; n < 3; n++)
                                s += longint'(img[(2*r+a+m)*14 + 2*c+b+n]) * longint'(wgt[m*3+n]);
                        if ((a == 0 && b == 0) || s > best) best = s;
                    end
                end
                exp_q.push_back(best[OW-1:0]);
            end
        end
    endtask

    task automatic send_frame(input bit xw);
        for (int i = 0; i < 196; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_ifm   = img[i];
            if (i < 9)      in_weight = wgt[i];
            else if (xw)    in_weight = 'x;
            else            in_weight = IW'($urandom());
            if (i == 195) start_q.push_back(cyc + 146);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        in_ifm    = '0;
        in_weight = '0;
    endtask

    task automatic wait_done();
        int n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 600) begin
            @(negedge clk);
            n++;
        end
        chk("drain_in_budget", 64'(n < 600), 64'd1);
        repeat (2) @(negedge clk);
    endtask

    // Monitor: pops the scoreboard on every output beat, checks idle zeros and burst length
    initial begin
        int run = 0;
        bit prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                run = 0;
                prev = 1'b0;
            end else if (out_valid) begin
                if (!prev) begin
                    chk("burst_expected", 64'(start_q.size() != 0), 64'd1);
                    if (start_q.size() != 0) chk("first_out_cycle", cyc, start_q.pop_front());
                end
                chk("output_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) chk("ofm", out_ofm, exp_q.pop_front());
                run++;
                prev = 1'b1;
            end else begin
                chk("ofm_idle_zero", out_ofm, 64'd0);
                if (prev) chk("burst_len", run, 64'd36);
                run = 0;
                prev = 1'b0;
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_valid", out_valid, 0);
        chk("reset_ofm", out_ofm, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // All ones: every pooled value is 9
        for (int i = 0; i < 196; i++) img[i] = 1;
        for (int i = 0; i < 9; i++) wgt[i] = 1;
        for (int k = 0; k < 36; k++) exp_q.push_back(36'd9);
        send_frame(1'b1);
        wait_done();

        // Ramp with centre-tap kernel: P(r,c) = 14(2r+2)+2c+2 (30 .. 180)
        for (int i = 0; i < 196; i++) img[i] = IW'(i);
        for (int i = 0; i < 9; i++) wgt[i] = (i == 4) ? 16'd1 : 16'd0;
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 6; c++)
                exp_q.push_back(OW'(14*(2*r+2) + 2*c + 2));
        send_frame(1'b1);
        wait_done();

        // Full-scale operands: 9 * 65535^2 without overflow
        for (int i = 0; i < 196; i++) img[i] = 16'hFFFF;
        for (int i = 0; i < 9; i++) wgt[i] = 16'hFFFF;
        for (int k = 0; k < 36; k++) exp_q.push_back(36'd38653526025);
        send_frame(1'b1);
        wait_done();

        // Reset at beat 100 of a frame
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_ifm   = IW'(i);
            in_weight = IW'(i);
        end
        @(posedge clk);
        #2 rst = 1'b1;
        in_valid = 1'b0;
        #1;
        chk("midload_rst_valid", out_valid, 0);
        chk("midload_rst_ofm", out_ofm, 0);
        @(posedge clk);
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 196; i++) img[i] = IW'((i * 37) % 101);
        for (int i = 0; i < 9; i++) wgt[i] = IW'(i + 1);
        push_model();
        send_frame(1'b0);
        wait_done();

        // Reset in the middle of an output burst
        for (int i = 0; i < 9; i++) wgt[i] = IW'(9 - i);
        push_model();
        send_frame(1'b0);
        begin
            int n = 0;
            while (!out_valid && n < 300) begin
                @(negedge clk);
                n++;
            end
            chk("burst_started", 64'(out_valid), 64'd1);
        end
        repeat (5) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midout_rst_valid", out_valid, 0);
        chk("midout_rst_ofm", out_ofm, 0);
        exp_q.delete();
        start_q.delete();
        @(posedge clk);
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        push_model();
        send_frame(1'b0);
        wait_done();

        // Random frames, short gap between frames
        for (int f = 0; f < 150; f++) begin
            for (int i = 0; i < 196; i++) img[i] = IW'($urandom());
            for (int i = 0; i < 9; i++) wgt[i] = IW'($urandom());
            push_model();
            send_frame(1'b0);
            wait_done();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
